// File: rtl/parameter_pkg.sv
// Shared constants for the APB address decoder.
//   burst_e          : AXI AxBURST encodings
//   ERRCNT_W_DEFAULT : default width of the decode-error counter
//   A_START / A_END  : inclusive byte range of each slave (up to 16)
//   wrap_len_ok      : legal AxLEN values for a WRAP burst
package parameter_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  localparam int ERRCNT_W_DEFAULT = 16;
  localparam int MAX_SLAVES       = 16;

  localparam logic [31:0] A_START [0:15] = '{
    32'h4000_0000, 32'h4000_1000, 32'h4000_2000, 32'h4000_3000,
    32'h4000_4000, 32'h4000_5000, 32'h4000_6000, 32'h4000_7000,
    32'h4000_8000, 32'h4000_9000, 32'h4000_A000, 32'h4000_B000,
    32'h4000_C000, 32'h4000_D000, 32'h4000_E000, 32'h4000_F000
  };

  localparam logic [31:0] A_END [0:15] = '{
    32'h4000_0FFF, 32'h4000_1FFF, 32'h4000_2FFF, 32'h4000_3FFF,
    32'h4000_4FFF, 32'h4000_5FFF, 32'h4000_6FFF, 32'h4000_7FFF,
    32'h4000_8FFF, 32'h4000_9FFF, 32'h4000_AFFF, 32'h4000_BFFF,
    32'h4000_CFFF, 32'h4000_DFFF, 32'h4000_EFFF, 32'h4000_FFFF
  };

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/region_match.sv
// Checks whether a burst byte range lies entirely inside one slave window.
//   low      : first byte of the burst
//   high     : last byte of the burst, one extra bit to carry an overflow
//   base     : first byte of the slave window
//   end_addr : last byte of the slave window (inclusive)
//   hit      : 1 when low..high is fully contained in base..end_addr
module region_match #(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] low,
  input  logic [ADDR_W:0]   high,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] end_addr,
  output logic              hit
);

  // An overflowed high (top bit set) can never be <= a zero-extended end.
  assign hit = (low >= base) && (high <= {1'b0, end_addr});

endmodule

// File: rtl/addr_decode_pipe.sv
// Two-stage valid/ready APB address decoder for AXI bursts.
//   clk_i, rst_i                  : clock, synchronous active-high reset
//   req_valid_i / req_ready_o     : upstream request handshake
//   start_addr_i, len_i, size_i,
//   burst_i                       : AXI burst description
//   dec_valid_o / dec_ready_i     : downstream result handshake
//   psel_o, slave_idx_o           : one-hot and binary selected slave
//   dec_error_o                   : no slave fully covers the burst
//   nonexist_transfer_o           : unsupported burst/size/length
//   err_cnt_o                     : saturating count of delivered decode errors
// Stage 1 holds the computed byte range, stage 2 holds the decode result.
module addr_decode_pipe
  import parameter_pkg::*;
#(
  parameter int SLAVE_CNT = 4,
  parameter int ADDR_W    = 32,
  parameter int ERRCNT_W  = ERRCNT_W_DEFAULT
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [ADDR_W-1:0]    start_addr_i,
  input  logic [7:0]           len_i,
  input  logic [2:0]           size_i,
  input  logic [1:0]           burst_i,
  output logic                 dec_valid_o,
  input  logic                 dec_ready_i,
  output logic [SLAVE_CNT-1:0] psel_o,
  output logic [3:0]           slave_idx_o,
  output logic                 dec_error_o,
  output logic                 nonexist_transfer_o,
  output logic [ERRCNT_W-1:0]  err_cnt_o
);

  localparam int AW1 = ADDR_W + 1;

  logic              s1_valid, s2_valid, s1_advance;
  logic [ADDR_W-1:0] s1_low;
  logic [AW1-1:0]    s1_high;
  logic              s1_nonexist;

  logic [AW1-1:0]    start_x, bytes, low_c, high_c;
  logic              nonexist_c;

  logic [SLAVE_CNT-1:0] hit, psel_c;
  logic [3:0]           idx_c;
  logic                 err_c;

  assign s1_advance  = !s2_valid || dec_ready_i;
  assign req_ready_o = !s1_valid || s1_advance;
  assign dec_valid_o = s2_valid;

  // Burst byte range; all arithmetic is one bit wider so a wrap past the
  // top of the address space shows up as high[ADDR_W].
  always_comb begin
    start_x = {1'b0, start_addr_i};
    bytes   = AW1'({len_i, 2'b00}) + AW1'(4);
    low_c   = start_x;
    high_c  = start_x + AW1'(3);
    case (burst_e'(burst_i))
      BURST_INCR: high_c = start_x + bytes - AW1'(1);
      BURST_WRAP: begin
        low_c  = start_x & ~(bytes - AW1'(1));
        high_c = low_c + bytes - AW1'(1);
      end
      default: ;
    endcase
    nonexist_c = (burst_i == BURST_RSVD) || (size_i != 3'd2) ||
                 ((burst_i == BURST_WRAP) && !wrap_len_ok(len_i));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid    <= 1'b0;
      s1_low      <= '0;
      s1_high     <= '0;
      s1_nonexist <= 1'b0;
    end else if (req_ready_o) begin
      s1_valid <= req_valid_i;
      if (req_valid_i) begin
        s1_low      <= low_c[ADDR_W-1:0];
        s1_high     <= high_c;
        s1_nonexist <= nonexist_c;
      end
    end
  end

  for (genvar i = 0; i < SLAVE_CNT; i++) begin : g_slave
    region_match #(.ADDR_W(ADDR_W)) u_match (
      .low      (s1_low),
      .high     (s1_high),
      .base     (ADDR_W'(A_START[i])),
      .end_addr (ADDR_W'(A_END[i])),
      .hit      (hit[i])
    );
  end

  always_comb begin
    psel_c = (s1_nonexist || s1_high[ADDR_W]) ? '0 : hit;
    idx_c  = '0;
    for (int i = 0; i < SLAVE_CNT; i++) begin
      if (psel_c[i]) idx_c = 4'(i);
    end
    err_c = !s1_nonexist && (psel_c == '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s2_valid            <= 1'b0;
      psel_o              <= '0;
      slave_idx_o         <= '0;
      dec_error_o         <= 1'b0;
      nonexist_transfer_o <= 1'b0;
    end else if (s1_advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        psel_o              <= psel_c;
        slave_idx_o         <= idx_c;
        dec_error_o         <= err_c;
        nonexist_transfer_o <= s1_nonexist;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_cnt_o <= '0;
    end else if (s2_valid && dec_ready_i && dec_error_o && (err_cnt_o != '1)) begin
      err_cnt_o <= err_cnt_o + ERRCNT_W'(1);
    end
  end

endmodule

// File: tb/tb_addr_decode_pipe.sv
module tb_addr_decode_pipe;

  localparam logic [1:0] B_FIXED = 2'b00;
  localparam logic [1:0] B_INCR  = 2'b01;
  localparam logic [1:0] B_WRAP  = 2'b10;
  localparam logic [1:0] B_RSVD  = 2'b11;

  typedef struct packed {
    logic [3:0] psel;
    logic [3:0] idx;
    logic       err;
    logic       nx;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] start_addr = '0;
  logic [7:0]  len = '0;
  logic [2:0]  size = 3'd2;
  logic [1:0]  burst = B_INCR;
  logic        dec_valid;
  logic        dec_ready = 1'b1;
  logic [3:0]  psel;
  logic [3:0]  slave_idx;
  logic        dec_error;
  logic        nonexist;
  logic [15:0] err_cnt;

  logic        req_ready_s, dec_valid_s, dec_error_s, nonexist_s;
  logic [3:0]  psel_s, slave_idx_s;
  logic [2:0]  err_cnt_s;

  int n_chk  = 0;
  int n_fail = 0;

  exp_t        sb[$];
  logic [15:0] exp_cnt   = '0;
  logic [2:0]  exp_cnt_s = '0;

  always #5 clk = ~clk;

  addr_decode_pipe dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .start_addr_i(start_addr), .len_i(len), .size_i(size), .burst_i(burst),
    .dec_valid_o(dec_valid), .dec_ready_i(dec_ready),
    .psel_o(psel), .slave_idx_o(slave_idx),
    .dec_error_o(dec_error), .nonexist_transfer_o(nonexist),
    .err_cnt_o(err_cnt)
  );

  // Narrow-counter copy sharing all inputs, used to reach saturation quickly.
  addr_decode_pipe #(.ERRCNT_W(3)) dut_sat (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready_s),
    .start_addr_i(start_addr), .len_i(len), .size_i(size), .burst_i(burst),
    .dec_valid_o(dec_valid_s), .dec_ready_i(dec_ready),
    .psel_o(psel_s), .slave_idx_o(slave_idx_s),
    .dec_error_o(dec_error_s), .nonexist_transfer_o(nonexist_s),
    .err_cnt_o(err_cnt_s)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [7:0] l,
                                 input logic [2:0] s, input logic [1:0] b);
    exp_t e;
    longint unsigned lo, hi, nbytes, base;
    e      = '0;
    nbytes = (longint'(l) + 1) * 4;
    lo     = longint'(a);
    hi     = lo + 3;
    if (b == B_INCR) hi = lo + nbytes - 1;
    else if (b == B_WRAP) begin
      lo = lo - (lo % nbytes);
      hi = lo + nbytes - 1;
    end
    e.nx = (b == B_RSVD) || (s != 3'd2) ||
           ((b == B_WRAP) && !(l == 1 || l == 3 || l == 7 || l == 15));
    if (!e.nx) begin
      for (int i = 0; i < 4; i++) begin
        base = 64'h4000_0000 + longint'(i) * 64'h1000;
        if (lo >= base && hi <= base + 64'hFFF) begin
          e.psel[i] = 1'b1;
          e.idx     = 4'(i);
        end
      end
      e.err = (e.psel == 4'b0);
    end
    return e;
  endfunction

  // Call at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [31:0] a, input logic [7:0] l,
                      input logic [2:0] s, input logic [1:0] b);
    logic accepted;
    accepted   = 1'b0;
    req_valid  = 1'b1;
    start_addr = a;
    len        = l;
    size       = s;
    burst      = b;
    for (int k = 0; k < 50 && !accepted; k++) begin
      @(negedge clk);
      if (req_ready) begin
        accepted = 1'b1;
        sb.push_back(model(a, l, s, b));
      end
      @(posedge clk);
      #1;
    end
    if (!accepted) check_eq("send_timeout", 32'(accepted), 32'd1);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && sb.size() != 0; k++) @(negedge clk);
    check_eq("drain", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
      exp_cnt   = '0;
      exp_cnt_s = '0;
    end else begin
      check_eq("err_cnt", 32'(err_cnt), 32'(exp_cnt));
      check_eq("err_cnt_sat", 32'(err_cnt_s), 32'(exp_cnt_s));
      if (dec_valid && dec_ready) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_result", 32'(dec_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          check_eq("psel", 32'(psel), 32'(e.psel));
          check_eq("slave_idx", 32'(slave_idx), 32'(e.idx));
          check_eq("dec_error", 32'(dec_error), 32'(e.err));
          check_eq("nonexist", 32'(nonexist), 32'(e.nx));
          if (e.err) begin
            if (exp_cnt != 16'hFFFF) exp_cnt++;
            if (exp_cnt_s != 3'd7) exp_cnt_s++;
          end
        end
      end
    end
  end

  initial begin
    int lens[6];
    exp_t e1;
    lens = '{0, 1, 2, 3, 7, 15};

    // Reset and first cycle after release.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_req_ready", 32'(req_ready), 32'd1);
    check_eq("rst_dec_valid", 32'(dec_valid), 32'd0);
    check_eq("rst_psel", 32'(psel), 32'd0);
    check_eq("rst_idx", 32'(slave_idx), 32'd0);
    check_eq("rst_flags", 32'({dec_error, nonexist}), 32'd0);
    @(posedge clk);
    #1;

    // INCR len=3 into slave 1, with latency check.
    send(32'h4000_1010, 8'd3, 3'd2, B_INCR);
    @(negedge clk);
    check_eq("lat_cycle1", 32'(dec_valid), 32'd0);
    @(negedge clk);
    check_eq("lat_cycle2", 32'(dec_valid), 32'd1);
    check_eq("incr_psel", 32'(psel), 32'b0010);
    @(posedge clk);
    #1;
    drain();

    // Boundary crossing -> DECERR, count 1.
    send(32'h4000_0FF8, 8'd3, 3'd2, B_INCR);
    drain();
    check_eq("cross_err_cnt", 32'(err_cnt), 32'd1);

    // WRAP legal/illegal, reserved burst, bad size, FIXED, hole, overflow.
    send(32'h4000_200C, 8'd3, 3'd2, B_WRAP);
    send(32'h4000_200C, 8'd2, 3'd2, B_WRAP);
    send(32'h4000_0000, 8'd0, 3'd2, B_RSVD);
    send(32'h4000_3000, 8'd0, 3'd1, B_INCR);
    send(32'h4000_3FFC, 8'd0, 3'd2, B_FIXED);
    send(32'h4000_4000, 8'd0, 3'd2, B_INCR);
    send(32'h3FFF_FFFC, 8'd0, 3'd2, B_INCR);
    send(32'hFFFF_FFFC, 8'd1, 3'd2, B_INCR);
    drain();

    // Stall: 2 accepted, then ready drops; first result held; release.
    dec_ready = 1'b0;
    e1 = model(32'h4000_0010, 8'd0, 3'd2, B_INCR);
    fork
      begin
        send(32'h4000_0010, 8'd0, 3'd2, B_INCR);
        send(32'h4000_1020, 8'd0, 3'd2, B_INCR);
        send(32'h4000_3000, 8'd0, 3'd2, B_INCR);
      end
    join_none
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check_eq("stall_req_ready", 32'(req_ready), 32'd0);
      check_eq("stall_valid", 32'(dec_valid), 32'd1);
      check_eq("stall_psel", 32'(psel), 32'(e1.psel));
      @(negedge clk);
    end
    @(posedge clk);
    #1 dec_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("release_consecutive", 32'(dec_valid), 32'd1);
    end
    wait fork;
    drain();

    // Random traffic with random backpressure.
    fork
      begin
        for (int k = 0; k < 300; k++) begin
          @(posedge clk);
          #1 dec_ready = 1'($urandom_range(0, 1));
        end
        dec_ready = 1'b1;
      end
      begin
        for (int k = 0; k < 40; k++) begin
          send(32'h4000_0000 + ($urandom_range(0, 32'h4FFF) & ~32'h3),
               8'(lens[$urandom_range(0, 5)]),
               ($urandom_range(0, 7) == 0) ? 3'd1 : 3'd2,
               2'($urandom_range(0, 3)));
        end
      end
    join
    dec_ready = 1'b1;
    drain();

    // Saturation of the 3-bit counter copy.
    for (int k = 0; k < 10; k++) send(32'hFFFF_FFFC, 8'd1, 3'd2, B_INCR);
    drain();
    check_eq("sat_all_ones", 32'(err_cnt_s), 32'd7);

    // Reset with 2 requests in flight.
    dec_ready = 1'b0;
    send(32'h4000_0100, 8'd0, 3'd2, B_INCR);
    send(32'h4000_1100, 8'd0, 3'd2, B_INCR);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    dec_ready = 1'b1;
    @(negedge clk);
    check_eq("midrst_valid", 32'(dec_valid), 32'd0);
    check_eq("midrst_req_ready", 32'(req_ready), 32'd1);
    check_eq("midrst_err_cnt", 32'(err_cnt), 32'd0);
    repeat (5) @(negedge clk);
    check_eq("midrst_no_result", 32'(dec_valid), 32'd0);
    check_eq("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/addr_decode_pipe.md
ADDR_DECODE_PIPE -- requirements
Module: addr_decode_pipe

Interface
REQ-001 Parameter SLAVE_CNT, default 4, number of APB slaves decoded (legal 1..16).
REQ-002 Parameter ADDR_W, default 32, address width.
REQ-003 Parameter ERRCNT_W, default 16, width of the decode-error counter.
REQ-004 clk_i  input  1  single clock; all logic on its rising edge.
REQ-005 rst_i  input  1  reset, synchronous, active-high.
REQ-006 req_valid_i / req_ready_o  in/out  1/1  upstream handshake for one address request.
REQ-007 start_addr_i  input  ADDR_W  first byte address of the burst.
REQ-008 len_i / size_i / burst_i  input  8/3/2  AXI AxLEN, AxSIZE, AxBURST.
REQ-009 dec_valid_o / dec_ready_i  out/in  1/1  downstream handshake for a decoded result.
REQ-010 psel_o  output  SLAVE_CNT  one-hot selected slave; all-zero on any error.
REQ-011 slave_idx_o  output  4  binary index of the selected slave; 0 when psel_o is 0.
REQ-012 dec_error_o / nonexist_transfer_o  output  1/1  DECERR and unsupported-transfer flags.
REQ-013 err_cnt_o  output  ERRCNT_W  saturating count of delivered dec_error_o results.

Function
REQ-014 The block shall be a two-stage valid/ready pipeline: S1 registers the request and computes the burst byte range; S2 registers the decode.
REQ-015 Latency shall be 2 cycles from an accepted request to dec_valid_o, with one result per cycle sustained throughput.
REQ-016 A transfer happens on valid&ready; req_ready_o = !s1_valid | s1_advance; s1_advance = !s2_valid | dec_ready_i.
REQ-017 While dec_valid_o=1 and dec_ready_i=0, all decode outputs shall stay stable and no request shall be lost, reordered or duplicated.
REQ-018 nonexist_transfer_o shall be 1 when burst_i=2'b11, or size_i!=2, or burst_i=WRAP with len_i not in {1,3,7,15}.
REQ-019 Range for FIXED: low=start, high=start+3.
REQ-020 Range for INCR: low=start, high=start+((len+1)<<2)-1.
REQ-021 Range for WRAP: bytes=(len+1)<<2, low=start&~(bytes-1), high=low+bytes-1.
REQ-022 high shall be computed at ADDR_W+1 bits; a carry out shall force dec_error_o=1.
REQ-023 psel_o[i] shall be 1 iff !nonexist & low>=A_START[i] & high<=A_END[i].
REQ-024 dec_error_o shall be 1 iff !nonexist & psel_o==0, which covers holes, above-map addresses and bursts crossing a slave boundary.
REQ-025 nonexist_transfer_o=1 shall force dec_error_o=0 and psel_o=0.
REQ-026 err_cnt_o shall increment on each dec_valid_o&dec_ready_i with dec_error_o=1 and hold at all-ones.

Reset
REQ-027 When rst_i=1 at a clock edge, s1_valid, s2_valid, dec_valid_o, psel_o, slave_idx_o, dec_error_o, nonexist_transfer_o and err_cnt_o shall all be cleared to 0.
REQ-028 req_ready_o shall be 1 in the first cycle after reset is released.
REQ-029 Reset asserted mid-operation shall drop all in-flight requests, with no result delivered for them.

Structure
REQ-030 A_START[0:15], A_END[0:15], the burst-type enum and the ERRCNT default shall live in parameter_pkg.
REQ-031 Default map: slave i occupies 0x4000_0000+i*0x1000 to +0xFFF.
REQ-032 One sub-module, region_match (low, high, base, end -> hit), shall be instantiated per slave through a generate loop.

Verification
REQ-033 INCR, len=3, size=2, addr 0x4000_1010 -> 2 cycles later psel_o=4'b0010, slave_idx_o=1, dec_error_o=0.
REQ-034 INCR, len=3, addr 0x4000_0FF8 (crosses into slave 1) -> psel_o=0, dec_error_o=1, err_cnt_o=1.
REQ-035 WRAP, len=3, addr 0x4000_200C -> psel_o=4'b0100; WRAP len=2 -> nonexist_transfer_o=1, dec_error_o=0; burst=2'b11 -> nonexist_transfer_o=1.
REQ-036 Stall sequence: hold dec_ready_i=0 and send 3 back-to-back requests -> req_ready_o falls after 2 are accepted and the first result stays stable; then release dec_ready_i -> 3 results are delivered in order on consecutive cycles.
REQ-037 Address 0xFFFF_FFFC, INCR len=1 (overflow) -> dec_error_o=1; repeat with err_cnt_o preloaded near max -> count saturates at 0xFFFF.
REQ-038 Assert rst_i with 2 requests in flight -> dec_valid_o=0 the next cycle, no result is delivered, req_ready_o=1.
